bf16_op_scheduler: RTL and testbench

- Shares one bf16_accelerator_top between NUM_REQ requesters.
- Round-robin arbitration of request handshakes; issues one operation per cycle to the accelerator.
- Tracks in-flight operations in an owner-tag FIFO and routes each accelerator result and fpcsr back to the requester that issued it.
- Accumulates sticky exception flags for software.

---
 rtl/bf16_op_scheduler_if.sv | 43 ++++
 rtl/bf16_op_scheduler.sv | 122 ++++++++++++
 tb/tb_bf16_op_scheduler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf16_op_scheduler_if.sv
// Requester and accelerator bundle for the bf16 op scheduler.
// master = environment side, slave = scheduler side.
interface bf16_op_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [4*NUM_REQ-1:0]  req_operation;
    logic [16*NUM_REQ-1:0] req_operand_a;
    logic [16*NUM_REQ-1:0] req_operand_b;
    logic [16*NUM_REQ-1:0] req_operand_c;

    logic        acc_enable;
    logic [3:0]  acc_operation;
    logic [15:0] acc_operand_a;
    logic [15:0] acc_operand_b;
    logic [15:0] acc_operand_c;
    logic [15:0] acc_result;
    logic [3:0]  acc_fpcsr;
    logic        acc_valid;

    logic [NUM_REQ-1:0] rsp_valid;
    logic [15:0]        rsp_result;
    logic [3:0]         rsp_fpcsr;

    modport master (
        output req_valid, req_operation,
        output req_operand_a, req_operand_b, req_operand_c,
        output acc_result, acc_fpcsr, acc_valid,
        input  req_ready, acc_enable, acc_operation,
        input  acc_operand_a, acc_operand_b, acc_operand_c,
        input  rsp_valid, rsp_result, rsp_fpcsr
    );

    modport slave (
        input  req_valid, req_operation,
        input  req_operand_a, req_operand_b, req_operand_c,
        input  acc_result, acc_fpcsr, acc_valid,
        output req_ready, acc_enable, acc_operation,
        output acc_operand_a, acc_operand_b, acc_operand_c,
        output rsp_valid, rsp_result, rsp_fpcsr
    );
endinterface

// File: rtl/bf16_op_scheduler.sv
// Round-robin sharing of one bf16 accelerator between NUM_REQ requesters,
// with an owner-tag FIFO routing in-order results back to their issuers.
module bf16_op_scheduler #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bf16_op_scheduler_if.slave   bus,
    input  logic                 flags_clear,
    output logic [3:0]           sticky_fpcsr,
    output logic                 spurious_err,
    output logic                 busy
);
    localparam int TW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] LAST    = TW'(NUM_REQ - 1);

    logic [TW-1:0]      rr_ptr;
    logic [TW-1:0]      gidx;
    logic [TW-1:0]      head;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_hot;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nxt;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [TW-1:0]      tag_mem [MAX_OUTSTANDING];
    logic               full;
    logic               accept;
    logic               complete;

    always_comb begin : arb
        int idx;
        found = 1'b0;
        gidx  = '0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gidx  = TW'(idx);
            end
        end
        if (found)
            grant[gidx] = 1'b1;
    end

    // Full is judged on the registered count only, so a completion in the
    // same cycle cannot open a slot combinationally.
    assign full          = (count == MAX_CNT);
    assign bus.req_ready = full ? '0 : grant;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign complete      = bus.acc_valid && (count != '0);
    assign head          = tag_mem[rd_ptr];

    always_comb begin
        rsp_hot = '0;
        rsp_hot[head] = 1'b1;
    end

    always_comb begin
        count_nxt = count;
        if (accept && !complete)
            count_nxt = count + 1'b1;
        else if (!accept && complete)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_mem[wr_ptr] <= gidx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr            <= '0;
            count             <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            busy              <= 1'b0;
            bus.acc_enable    <= 1'b0;
            bus.acc_operation <= '0;
            bus.acc_operand_a <= '0;
            bus.acc_operand_b <= '0;
            bus.acc_operand_c <= '0;
            bus.rsp_valid     <= '0;
            bus.rsp_result    <= '0;
            bus.rsp_fpcsr     <= '0;
            sticky_fpcsr      <= '0;
            spurious_err      <= 1'b0;
        end else begin
            count          <= count_nxt;
            busy           <= (count_nxt != '0);
            bus.acc_enable <= accept;
            if (accept) begin
                bus.acc_operation <= bus.req_operation[gidx*4 +: 4];
                bus.acc_operand_a <= bus.req_operand_a[gidx*16 +: 16];
                bus.acc_operand_b <= bus.req_operand_b[gidx*16 +: 16];
                bus.acc_operand_c <= bus.req_operand_c[gidx*16 +: 16];
                wr_ptr            <= wr_ptr + 1'b1;
                rr_ptr            <= (gidx == LAST) ? '0 : gidx + 1'b1;
            end
            bus.rsp_valid <= complete ? rsp_hot : '0;
            if (complete) begin
                bus.rsp_result <= bus.acc_result;
                bus.rsp_fpcsr  <= bus.acc_fpcsr;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (bus.acc_valid && (count == '0))
                spurious_err <= 1'b1;
            sticky_fpcsr <= (flags_clear ? 4'h0 : sticky_fpcsr)
                          | (complete ? bus.acc_fpcsr : 4'h0);
        end
    end
endmodule

// File: tb/tb_bf16_op_scheduler.sv
// Scoreboard bench for bf16_op_scheduler: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_bf16_op_scheduler;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flags_clear = 1'b0;
    logic [3:0] sticky_fpcsr;
    logic       spurious_err;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]  hot;
        logic [15:0] res;
        logic [3:0]  f;
    } exp_t;

    exp_t exp_q[$];

    bf16_op_scheduler_if #(.NUM_REQ(2)) bus ();

    bf16_op_scheduler #(
        .NUM_REQ(2),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .flags_clear(flags_clear),
        .sticky_fpcsr(sticky_fpcsr),
        .spurious_err(spurious_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One acc_valid pulse; when a response is due its expectation is queued.
    task automatic pulse(input logic [15:0] res, input logic [3:0] f,
                         input logic [1:0] hot, input bit due);
        bus.acc_valid  = 1'b1;
        bus.acc_result = res;
        bus.acc_fpcsr  = f;
        if (due)
            exp_q.push_back('{hot: hot, res: res, f: f});
        step();
        bus.acc_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_valid", 32'(bus.rsp_valid), 32'(e.hot));
                check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                check("rsp_fpcsr", 32'(bus.rsp_fpcsr), 32'(e.f));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid     = '0;
        bus.req_operation = '0;
        bus.req_operand_a = '0;
        bus.req_operand_b = '0;
        bus.req_operand_c = '0;
        bus.acc_valid     = 1'b0;
        bus.acc_result    = '0;
        bus.acc_fpcsr     = '0;

        // reset held for 3 cycles
        step(); step();
        @(negedge clk);
        check("rst_acc_enable", 32'(bus.acc_enable), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_spurious", 32'(spurious_err), 32'h0);
        check("rst_sticky", 32'(sticky_fpcsr), 32'h0);
        check("rst_acc_a", 32'(bus.acc_operand_a), 32'h0);
        step();
        reset_n = 1'b1;

        // single op
        bus.req_valid     = 2'b01;
        bus.req_operation = 8'h02;
        bus.req_operand_a = 32'h0000_4000;
        bus.req_operand_b = 32'h0000_3F80;
        @(negedge clk);
        check("t1_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid  = 2'b00;
        bus.acc_valid  = 1'b1;
        bus.acc_result = 16'h3F80;
        bus.acc_fpcsr  = 4'h0;
        exp_q.push_back('{hot: 2'b01, res: 16'h3F80, f: 4'h0});
        @(negedge clk);
        check("t1_acc_enable", 32'(bus.acc_enable), 32'h1);
        check("t1_acc_a", 32'(bus.acc_operand_a), 32'h4000);
        check("t1_acc_b", 32'(bus.acc_operand_b), 32'h3F80);
        check("t1_acc_op", 32'(bus.acc_operation), 32'h2);
        check("t1_busy", 32'(busy), 32'h1);
        step();
        bus.acc_valid = 1'b0;
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'h0);
        check("t1_enable_low", 32'(bus.acc_enable), 32'h0);
        check("t1_acc_a_hold", 32'(bus.acc_operand_a), 32'h4000);

        // fairness: both requesters valid for 12 grants
        step();
        do_reset();
        bus.req_valid     = 2'b11;
        bus.req_operand_a = 32'hB001_A000;
        for (int n = 0; n < 12; n++) begin
            if (n > 0)
                pulse_start(16'h1000 + 16'(n - 1), (n % 2 == 1) ? 2'b01 : 2'b10);
            @(negedge clk);
            check("fair_ready", 32'(bus.req_ready),
                  (n % 2 == 0) ? 32'h1 : 32'h2);
            if (n > 0) begin
                check("fair_enable", 32'(bus.acc_enable), 32'h1);
                check("fair_acc_a", 32'(bus.acc_operand_a),
                      (n % 2 == 1) ? 32'hA000 : 32'hB001);
            end
            step();
            bus.acc_valid = 1'b0;
        end
        bus.req_valid = 2'b00;
        pulse(16'h100B, 4'h0, 2'b10, 1'b1);
        @(negedge clk);
        check("fair_busy_end", 32'(busy), 32'h0);

        // full: four accepts then no ready until a completion lands
        step();
        do_reset();
        bus.req_valid = 2'b01;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("full_ready_on", 32'(bus.req_ready), 32'h1);
            step();
        end
        @(negedge clk);
        check("full_ready_off", 32'(bus.req_ready), 32'h0);
        check("full_busy", 32'(busy), 32'h1);
        step();
        bus.acc_valid  = 1'b1;
        bus.acc_result = 16'h2000;
        bus.acc_fpcsr  = 4'h0;
        exp_q.push_back('{hot: 2'b01, res: 16'h2000, f: 4'h0});
        @(negedge clk);
        check("full_same_cycle", 32'(bus.req_ready), 32'h0);
        step();
        bus.acc_valid = 1'b0;
        @(negedge clk);
        check("full_reopen", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b00;
        pulse(16'h2001, 4'b0001, 2'b01, 1'b1);
        pulse(16'h2002, 4'b0100, 2'b01, 1'b1);
        pulse(16'h2003, 4'b0000, 2'b01, 1'b1);
        pulse(16'h2004, 4'b0000, 2'b01, 1'b1);
        @(negedge clk);
        check("sticky_or", 32'(sticky_fpcsr), 32'h5);
        check("full_drained", 32'(busy), 32'h0);

        // clear coinciding with a completion keeps the new flags
        step();
        bus.req_valid = 2'b10;
        @(negedge clk);
        check("clr_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 2'b00;
        flags_clear   = 1'b1;
        pulse(16'h2100, 4'b1000, 2'b10, 1'b1);
        flags_clear = 1'b0;
        @(negedge clk);
        check("sticky_clear", 32'(sticky_fpcsr), 32'h8);

        // simultaneous accept and completion at outstanding = 2
        step();
        do_reset();
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("sim_ready0", 32'(bus.req_ready), 32'h1);
        step();
        @(negedge clk);
        check("sim_ready1", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 2'b01;
        pulse_start(16'h3000, 2'b01);
        @(negedge clk);
        check("sim_ready2", 32'(bus.req_ready), 32'h1);
        step();
        bus.acc_valid = 1'b0;
        bus.req_valid = 2'b10;
        @(negedge clk);
        check("sim_ready3", 32'(bus.req_ready), 32'h2);
        step();
        @(negedge clk);
        check("sim_ready4", 32'(bus.req_ready), 32'h2);
        step();
        @(negedge clk);
        check("sim_full", 32'(bus.req_ready), 32'h0);
        step();
        bus.req_valid = 2'b00;
        pulse(16'h3001, 4'h0, 2'b10, 1'b1);
        pulse(16'h3002, 4'h0, 2'b01, 1'b1);
        pulse(16'h3003, 4'h0, 2'b10, 1'b1);
        pulse(16'h3004, 4'h0, 2'b10, 1'b1);

        // spurious completion, then reset with ops in flight
        pulse(16'h4000, 4'h0, 2'b00, 1'b0);
        @(negedge clk);
        check("spur_set", 32'(spurious_err), 32'h1);
        step();
        bus.req_valid = 2'b01;
        step(); step(); step();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("inflight_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_rsp", 32'(bus.rsp_valid), 32'h0);
        check("arst_spur", 32'(spurious_err), 32'h0);
        check("arst_enable", 32'(bus.acc_enable), 32'h0);
        step(); step();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_spur", 32'(spurious_err), 32'h0);
        step();
        pulse(16'h5000, 4'h1, 2'b00, 1'b0);
        pulse(16'h5001, 4'h1, 2'b00, 1'b0);
        @(negedge clk);
        check("late_spur", 32'(spurious_err), 32'h1);
        check("late_busy", 32'(busy), 32'h0);
        check("late_sticky", 32'(sticky_fpcsr), 32'h0);

        step(); step();
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    // Raise acc_valid for a completion that is due; caller lowers it.
    task automatic pulse_start(input logic [15:0] res, input logic [1:0] hot);
        bus.acc_valid  = 1'b1;
        bus.acc_result = res;
        bus.acc_fpcsr  = 4'h0;
        exp_q.push_back('{hot: hot, res: res, f: 4'h0});
    endtask
endmodule
